core_clint: RTL and testbench

//   Core-local interruptor: 64-bit mtime counter, 64-bit mtimecmp, single-hart msip.

---
 rtl/core_clint.sv | 158 +++++++++++++++
 tb/tb_core_clint.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_clint.sv
// Core-local interruptor for a single hart: free-running 64-bit mtime with a
// prescaler, 64-bit mtimecmp compare, and a one-bit software interrupt.
module core_clint #(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [15:0] BASE_MASK = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [63:0] mtime_o,
    output logic        m_timer_irq_o,
    output logic        m_soft_irq_o
);

    localparam logic [15:0] OFF_MSIP       = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP_L = 16'h4000;
    localparam logic [15:0] OFF_MTIMECMP_H = 16'h4004;
    localparam logic [15:0] OFF_MTIME_L    = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_H    = 16'hBFFC;

    logic        ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q;
    logic        msip_q;
    logic        timer_irq_q;
    logic [31:0] presc_q;

    logic [15:0] offset;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_mtime_lo;
    logic        sel_mtime_hi;
    logic        misaligned;
    logic        access_err;
    logic        accept;
    logic        wr;
    logic        tick;
    logic        mtime_wr;
    logic [63:0] mtime_next;
    logic [31:0] rdata_mux;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign offset       = req_addr_i & BASE_MASK;
    assign sel_msip     = (offset == OFF_MSIP);
    assign sel_cmp_lo   = (offset == OFF_MTIMECMP_L);
    assign sel_cmp_hi   = (offset == OFF_MTIMECMP_H);
    assign sel_mtime_lo = (offset == OFF_MTIME_L);
    assign sel_mtime_hi = (offset == OFF_MTIME_H);
    assign misaligned   = |req_addr_i[1:0];
    assign access_err   = misaligned |
                          ~(sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mtime_lo | sel_mtime_hi);

    assign accept = req_valid_i & ready_q;
    assign wr     = accept & req_we_i & ~access_err;
    assign tick   = (presc_q == TICK_DIV - 1);

    // Reads see registered state only; a software write to either mtime half
    // overrides the tick for that cycle and restarts the prescaler.
    always_comb begin
        rdata_mux  = '0;
        mtime_next = mtime_q;
        mtime_wr   = 1'b0;
        if (sel_msip) begin
            rdata_mux = {31'd0, msip_q};
        end else if (sel_cmp_lo) begin
            rdata_mux = mtimecmp_q[31:0];
        end else if (sel_cmp_hi) begin
            rdata_mux = mtimecmp_q[63:32];
        end else if (sel_mtime_lo) begin
            rdata_mux = mtime_q[31:0];
        end else if (sel_mtime_hi) begin
            rdata_mux = mtime_q[63:32];
        end
        if (wr && (req_be_i != 4'd0)) begin
            if (sel_mtime_lo) begin
                mtime_next[31:0] = be_merge(mtime_q[31:0], req_wdata_i, req_be_i);
                mtime_wr         = 1'b1;
            end
            if (sel_mtime_hi) begin
                mtime_next[63:32] = be_merge(mtime_q[63:32], req_wdata_i, req_be_i);
                mtime_wr          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            timer_irq_q <= 1'b0;
            presc_q     <= '0;
        end else begin
            ready_q     <= 1'b1;
            rsp_valid_q <= accept;
            rsp_err_q   <= accept & access_err;
            rsp_rdata_q <= (accept && !access_err && !req_we_i) ? rdata_mux : 32'd0;
            timer_irq_q <= (mtime_q >= mtimecmp_q);

            if (wr && sel_msip && req_be_i[0]) begin
                msip_q <= req_wdata_i[0];
            end
            if (wr && sel_cmp_lo) begin
                mtimecmp_q[31:0] <= be_merge(mtimecmp_q[31:0], req_wdata_i, req_be_i);
            end
            if (wr && sel_cmp_hi) begin
                mtimecmp_q[63:32] <= be_merge(mtimecmp_q[63:32], req_wdata_i, req_be_i);
            end

            if (mtime_wr) begin
                mtime_q <= mtime_next;
                presc_q <= '0;
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 32'd1;
            end
        end
    end

    assign req_ready_o   = ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign mtime_o       = mtime_q;
    assign m_timer_irq_o = timer_irq_q;
    assign m_soft_irq_o  = msip_q;

endmodule

// File: tb/tb_core_clint.sv
// Bench for core_clint: table vectors, directed timer/reset sequences and
// random bus traffic checked against a register-level model of the CLINT.
module tb_core_clint;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [15:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [63:0] mtime_o;
    logic        m_timer_irq_o;
    logic        m_soft_irq_o;

    logic        div_ready;
    logic        div_rsp_valid;
    logic [31:0] div_rsp_rdata;
    logic        div_rsp_err;
    logic [63:0] div_mtime;
    logic        div_timer_irq;
    logic        div_soft_irq;

    int checks = 0;
    int errors = 0;

    // Model state: plain 64-bit registers updated once per clock edge.
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_msip;
    logic        m_tirq;
    logic        m_ready;
    logic        m_rv;
    logic        m_rerr;
    logic [31:0] m_rdata;
    int          div_edges;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[16];

    core_clint #(.TICK_DIV(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mtime_o(mtime_o), .m_timer_irq_o(m_timer_irq_o), .m_soft_irq_o(m_soft_irq_o)
    );

    core_clint #(.TICK_DIV(4)) dut_div (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(1'b0), .req_ready_o(div_ready),
        .req_we_i(1'b0), .req_addr_i(16'h0000),
        .req_wdata_i(32'h0), .req_be_i(4'h0),
        .rsp_valid_o(div_rsp_valid), .rsp_rdata_o(div_rsp_rdata), .rsp_err_o(div_rsp_err),
        .mtime_o(div_mtime), .m_timer_irq_o(div_timer_irq), .m_soft_irq_o(div_soft_irq)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic we, input logic [15:0] a,
                                  input logic [31:0] wd, input logic [3:0] be);
        req_valid_i = v;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = wd;
        req_be_i    = be;
    endtask

    task automatic model_edge(input logic rst, input logic v, input logic we,
                              input logic [15:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic        acc;
        logic        err;
        logic        written;
        logic [31:0] rd;
        if (!rst) begin
            m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0; m_tirq = 1'b0;
            m_ready = 1'b0; m_rv = 1'b0; m_rerr = 1'b0; m_rdata = 32'd0;
            div_edges = 0;
            return;
        end
        acc = v && m_ready;
        err = !(a inside {16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC});
        rd  = 32'd0;
        if (acc && !err && !we) begin
            case (a)
                16'h0000: rd = {31'd0, m_msip};
                16'h4000: rd = m_cmp[31:0];
                16'h4004: rd = m_cmp[63:32];
                16'hBFF8: rd = m_mtime[31:0];
                default:  rd = m_mtime[63:32];
            endcase
        end
        m_tirq  = (m_mtime >= m_cmp);
        m_rv    = acc;
        m_rerr  = acc && err;
        m_rdata = rd;
        m_ready = 1'b1;
        written = 1'b0;
        if (acc && we && !err) begin
            case (a)
                16'h0000: if (be[0]) m_msip = wd[0];
                16'h4000: m_cmp[31:0]  = merge(m_cmp[31:0], wd, be);
                16'h4004: m_cmp[63:32] = merge(m_cmp[63:32], wd, be);
                16'hBFF8: if (be != 4'd0) begin m_mtime[31:0]  = merge(m_mtime[31:0], wd, be);  written = 1'b1; end
                default:  if (be != 4'd0) begin m_mtime[63:32] = merge(m_mtime[63:32], wd, be); written = 1'b1; end
            endcase
        end
        if (!written) m_mtime = m_mtime + 64'd1;
        div_edges++;
    endtask

    // One clock: the inputs present at the edge feed the model, outputs are
    // sampled 1ns later and compared against it.
    task automatic step();
        logic        s_rst, s_v, s_we;
        logic [15:0] s_a;
        logic [31:0] s_wd;
        logic [3:0]  s_be;
        s_rst = rst_ni; s_v = req_valid_i; s_we = req_we_i;
        s_a = req_addr_i; s_wd = req_wdata_i; s_be = req_be_i;
        @(posedge clk_i);
        #1;
        model_edge(s_rst, s_v, s_we, s_a, s_wd, s_be);
        check_output("ready", req_ready_o, m_ready);
        check_output("rsp_valid", rsp_valid_o, m_rv);
        if (m_rv) begin
            check_output("rsp_err", rsp_err_o, m_rerr);
            check_output("rsp_rdata", rsp_rdata_o, m_rdata);
        end
        check_output("mtime", mtime_o, m_mtime);
        check_output("timer_irq", m_timer_irq_o, m_tirq);
        check_output("soft_irq", m_soft_irq_o, m_msip);
        check_output("div_mtime", div_mtime, 64'(div_edges / 4));
        check_output("div_rsp_valid", div_rsp_valid, 1'b0);
        check_output("div_irqs", {div_timer_irq, div_soft_irq}, 2'b00);
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 16'h0000, 32'h0, 4'h0);
    endtask

    initial begin
        logic        found;
        logic [15:0] addrs[10];
        logic [15:0] ra;

        vecs[0]  = '{1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 16'h0000, 32'h0,         4'h0, 1'b0, 32'h1};
        vecs[2]  = '{1'b1, 16'h0000, 32'h0,         4'hF, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 16'h0000, 32'h0,         4'h0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 16'h4002, 32'h0,         4'h0, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 16'h0100, 32'h0,         4'h0, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 16'h4000, 32'h1234_5678, 4'b0010, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 16'h4000, 32'h0,         4'h0, 1'b0, 32'hFFFF_56FF};
        vecs[8]  = '{1'b1, 16'h4004, 32'hAAAA_AAAA, 4'h0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 16'h4004, 32'h0,         4'h0, 1'b0, 32'hFFFF_FFFF};
        vecs[10] = '{1'b1, 16'h4003, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 16'h4000, 32'h0,         4'h0, 1'b0, 32'hFFFF_56FF};
        vecs[12] = '{1'b1, 16'h0000, 32'h0000_0001, 4'b0001, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 16'h0000, 32'h0,         4'h0, 1'b0, 32'h1};
        vecs[14] = '{1'b1, 16'hBFF4, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[15] = '{1'b1, 16'h0000, 32'h0,         4'hF, 1'b0, 32'h0};

        addrs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
                  16'h0100, 16'h4002, 16'hBFFA, 16'h0004, 16'h8000};

        $display("[TB] reset and idle counting");
        rst_ni = 1'b0;
        idle();
        repeat (3) step();
        check_output("reset_mtime", mtime_o, 64'd0);
        check_output("reset_ready", req_ready_o, 1'b0);
        rst_ni = 1'b1;
        repeat (40) step();
        check_output("idle40_div_mtime", div_mtime, 64'd10);
        check_output("idle40_mtime", mtime_o, 64'd40);

        $display("[TB] table vectors");
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            step();
            check_output($sformatf("tbl%0d_err", i), rsp_err_o, vecs[i].err);
            check_output($sformatf("tbl%0d_rdata", i), rsp_rdata_o, vecs[i].rdata);
        end
        idle();
        step();

        $display("[TB] timer compare rise and fall");
        apply_stimulus(1'b1, 1'b1, 16'hBFFC, 32'h0, 4'hF);  step();
        apply_stimulus(1'b1, 1'b1, 16'hBFF8, 32'h0, 4'hF);  step();
        apply_stimulus(1'b1, 1'b1, 16'h4000, 32'h20, 4'hF); step();
        apply_stimulus(1'b1, 1'b1, 16'h4004, 32'h0, 4'hF);  step();
        idle();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (m_timer_irq_o === 1'b1) found = 1'b1;
        end
        check_output("irq_rise_seen", found, 1'b1);
        check_output("irq_rise_mtime", mtime_o, 64'h21);
        apply_stimulus(1'b1, 1'b1, 16'h4004, 32'h1, 4'hF);
        step();
        check_output("irq_still_high", m_timer_irq_o, 1'b1);
        idle();
        step();
        check_output("irq_fell", m_timer_irq_o, 1'b0);

        $display("[TB] mtime wrap");
        apply_stimulus(1'b1, 1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF); step();
        apply_stimulus(1'b1, 1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF); step();
        check_output("wrap_allones", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check_output("wrap_write_err", rsp_err_o, 1'b0);
        idle();
        step();
        check_output("wrap_zero", mtime_o, 64'd0);

        $display("[TB] mtime write colliding with tick");
        apply_stimulus(1'b1, 1'b1, 16'hBFF8, 32'h1234, 4'hF); step();
        apply_stimulus(1'b1, 1'b0, 16'hBFF8, 32'h0, 4'h0);    step();
        check_output("collide_read", rsp_rdata_o, 32'h1234);
        idle();
        step();

        $display("[TB] reset during a transaction");
        apply_stimulus(1'b1, 1'b0, 16'h0000, 32'h0, 4'h0);
        rst_ni = 1'b0;
        step();
        check_output("reset_drop_rsp", rsp_valid_o, 1'b0);
        idle();
        step();
        check_output("reset_mid_mtime", mtime_o, 64'd0);
        rst_ni = 1'b1;
        step();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? 16'($urandom) : addrs[$urandom_range(0, 9)];
            apply_stimulus(($urandom_range(0, 9) < 7), 1'($urandom), ra,
                           $urandom, 4'($urandom));
            step();
        end
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
